fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Shares the single frame-buffer SRAM transaction port between three requesters: video line prefetch, CPU bus and blitter. Requester 0 has fixed priority, bounded by an anti-hog limit. Requesters 1 and 2 share the remaining slots round-robin. The block sits between the requesters and the frame-buffer SRAM control FSM and forwards exactly one transaction per grant.

## Interface

- HOG_LIMIT, default 8: maximum consecutive requester-0 grants while requester 1 or 2 is waiting; range 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rq_stb  in  3  per-requester strobe; bit i belongs to requester i. Held until that requester's ack.
- rq_we  in  3  per-requester write enable (1 = write).
- rq_addr  in  60  packed word addresses; requester i uses [20i+19:20i].
- rq_wdata  in  48  packed write data; requester i uses [16i+15:16i].
- rq_ack  out  3  per-requester acknowledge.
- rq_rdata  out  16  read data, shared by all requesters; valid while the requester's rq_ack is 1.
- mem_stb  out  1  strobe to the SRAM control FSM.
- mem_we  out  1  write enable to the SRAM control FSM.
- mem_addr  out  20  address to the SRAM control FSM.
- mem_wdata  out  16  write data to the SRAM control FSM.
- mem_rdata  in  16  read data from the SRAM control FSM.
- mem_ack  in  1  acknowledge from the SRAM control FSM; may stay high for several consecutive cycles.
- gnt  out  3  registered one-hot grant, or 000 when idle.
- busy  out  1  1 when the state is not IDLE.

## Operation

- States:
  - IDLE: gnt = 000.
  - GRANT: mem_stb = 1.
  - RELEASE: waits for mem_ack to drop.
- IDLE, rq_stb = 000: stay in IDLE.
- IDLE, any rq_stb set: arbitrate, load gnt, go to GRANT.
- GRANT, mem_ack = 0: stay in GRANT.
- GRANT, mem_ack = 1: go to RELEASE.
- RELEASE, mem_ack = 1: stay in RELEASE.
- RELEASE, mem_ack = 0: clear gnt, go to IDLE.
- Arbitration, evaluated only in IDLE:
  - Waiting means rq_stb[2:1] != 00.
  - If rq_stb[0] = 1 and (not waiting, or hog_cnt < HOG_LIMIT): grant requester 0.
    - hog_cnt increments if waiting.
    - hog_cnt clears if not waiting.
  - Otherwise grant round-robin among requesters 1 and 2, and clear hog_cnt.
  - Round-robin: if only one of rq_stb[2:1] is set, it wins. If both are set, the one not equal to rr_last wins.
  - rr_last (1 bit; 0 = requester 1, 1 = requester 2) updates only on a grant to requester 1 or 2.
- mem_stb = (state == GRANT).
- mem_we, mem_addr and mem_wdata are muxed combinationally from the granted requester whenever gnt != 000. When gnt = 000 they are 0.
- rq_ack[i] = mem_ack & gnt[i] & (state != IDLE).
- rq_rdata = mem_rdata, passed through combinationally.
- Grant is held by state, not by rq_stb:
  - If the granted requester drops rq_stb before ack, mem_stb stays 1 until the transaction completes.
  - Requests from the other requesters are ignored until IDLE.
- hog_cnt is 4 bits and saturates at HOG_LIMIT.

## Timing

- Reset values (asynchronous, immediate on rst_n = 0):
  - state = IDLE, gnt = 000, hog_cnt = 0, rr_last = 1 (requester 1 wins the first tie).
  - mem_stb = 0, busy = 0, rq_ack = 000.
- Reset mid-transaction drops mem_stb immediately, with no completion. Requesters must re-issue after reset.
- Latency:
  - rq_stb rising edge sampled at edge N → gnt and mem_stb high after edge N.
  - mem_ack first high in cycle M → rq_ack high in the same cycle M, for as many cycles as mem_ack stays high.
  - After mem_ack falls, state is back in IDLE one edge later.
- Minimum gap: one IDLE cycle between consecutive transactions. IDLE performs arbitration.
- With a 2-cycle mem_ack, mem_stb is high from cycle 1 until the first ack cycle inclusive.
- Simultaneous events:
  - Requests that arrive while not in IDLE wait.
  - All three requesters asserting in the same cycle is resolved by the rules above, with no bias beyond them.

## Test plan

- Single write: rq_stb = 010, rq_addr[39:20] = 0x00ABC, rq_wdata[31:16] = 0x739C, mem_ack high for 2 cycles → mem_addr = 0x00ABC, mem_wdata = 0x739C, mem_we = 1, rq_ack = 010 for exactly 2 cycles, then gnt = 000.
- Round-robin: rq_stb[2:1] held at 11, requester 0 idle → grant sequence 1, 2, 1, 2. rr_last toggles after each grant.
- Anti-hog: HOG_LIMIT = 3, rq_stb = 111 held continuously → grants 0, 0, 0, 1, 0, 0, 0, 2.
- Stb drop: the granted requester drops rq_stb before ack → mem_stb stays 1 until mem_ack. rq_ack is still pulsed to that requester.
- Async reset: assert rst_n = 0 mid-GRANT, between clock edges → mem_stb, gnt and busy are 0 immediately. After release, rq_stb = 110 grants requester 1 first.
- Read: requester 0 read with mem_rdata = 0x1234 during ack → rq_rdata = 0x1234 while rq_ack = 001. mem_we = 0 throughout.

Source files
------------

// File: rtl/fb_arbiter_if.sv
// Frame-buffer arbiter bus bundle: the three requester ports plus the SRAM control FSM port.
// Requester fields are packed per requester: addr[20i+19:20i], wdata[16i+15:16i], bit i elsewhere.
// master = the arbiter side, slave = the requesters + SRAM control FSM side.
interface fb_arbiter_if;
  // requester side
  logic [2:0]  rq_stb;
  logic [2:0]  rq_we;
  logic [59:0] rq_addr;
  logic [47:0] rq_wdata;
  logic [2:0]  rq_ack;
  logic [15:0] rq_rdata;
  // SRAM control FSM side
  logic        mem_stb;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  rq_stb, rq_we, rq_addr, rq_wdata, mem_rdata, mem_ack,
    output rq_ack, rq_rdata, mem_stb, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rq_stb, rq_we, rq_addr, rq_wdata, mem_rdata, mem_ack,
    input  rq_ack, rq_rdata, mem_stb, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Purpose: shares one frame-buffer SRAM transaction port among video (0, fixed priority with
//          anti-hog limit), CPU (1) and blitter (2) (round-robin between 1 and 2).
// Latency: request sampled at edge N -> gnt/mem_stb after edge N; rq_ack follows mem_ack combinationally.
// Backpressure: one transaction per grant; other requests wait until the arbiter returns to IDLE.
// Ports: clk, rst_n (async active-low); bus (fb_arbiter_if.master: rq_* and mem_* signals);
//        gnt (registered one-hot grant), busy (state != IDLE).
module fb_arbiter #(
  parameter int unsigned HOG_LIMIT = 8  // 1..15
) (
  input  logic           clk,
  input  logic           rst_n,
  fb_arbiter_if.master   bus,
  output logic [2:0]     gnt,
  output logic           busy
);

  localparam logic [3:0] HOG_MAX = 4'(HOG_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] gnt_d;
  logic [3:0] hog_q, hog_d;
  logic       rr_q, rr_d;     // last round-robin winner: 0 = requester 1, 1 = requester 2
  logic       waiting;
  logic       pick2;          // round-robin outcome: 1 = requester 2 wins

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= 3'b000;
      hog_q   <= 4'd0;
      rr_q    <= 1'b1;  // so requester 1 wins the first tie
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      hog_q   <= hog_d;
      rr_q    <= rr_d;
    end
  end

  // Round-robin choice between requesters 1 and 2
  always_comb begin
    waiting = |bus.rq_stb[2:1];
    pick2   = 1'b0;
    if (bus.rq_stb[2:1] == 2'b11) pick2 = ~rr_q;
    else                          pick2 = bus.rq_stb[2];
  end

  // Next-state and arbitration. The grant is owned by the state machine, so a requester
  // dropping rq_stb mid-transaction does not abort the SRAM cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    hog_d   = hog_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (|bus.rq_stb) begin
          state_d = GRANT;
          if (bus.rq_stb[0] && (!waiting || (hog_q < HOG_MAX))) begin
            gnt_d = 3'b001;
            // Only consecutive grants taken while others wait count against the limit.
            if (waiting) hog_d = (hog_q < HOG_MAX) ? hog_q + 4'd1 : hog_q;
            else         hog_d = 4'd0;
          end else begin
            hog_d = 4'd0;
            gnt_d = pick2 ? 3'b100 : 3'b010;
            rr_d  = pick2;
          end
        end
      end
      GRANT: begin
        if (bus.mem_ack) state_d = RELEASE;
      end
      RELEASE: begin
        // mem_ack may be held for several cycles; finish only once it drops.
        if (!bus.mem_ack) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // Transaction mux toward the SRAM control FSM
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 20'd0;
    bus.mem_wdata = 16'd0;
    case (gnt)
      3'b001: begin
        bus.mem_we    = bus.rq_we[0];
        bus.mem_addr  = bus.rq_addr[19:0];
        bus.mem_wdata = bus.rq_wdata[15:0];
      end
      3'b010: begin
        bus.mem_we    = bus.rq_we[1];
        bus.mem_addr  = bus.rq_addr[39:20];
        bus.mem_wdata = bus.rq_wdata[31:16];
      end
      3'b100: begin
        bus.mem_we    = bus.rq_we[2];
        bus.mem_addr  = bus.rq_addr[59:40];
        bus.mem_wdata = bus.rq_wdata[47:32];
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_stb  = (state_q == GRANT);
  assign bus.rq_ack   = gnt & {3{bus.mem_ack & (state_q != IDLE)}};
  assign bus.rq_rdata = bus.mem_rdata;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: a reference arbitration model pushes the expected transaction
// when request patterns are driven; each SRAM strobe pops and compares one entry.
// Memory side is driven by the bench acting as the SRAM control FSM.
module tb_fb_arbiter;

  localparam int HL = 3;

  typedef struct {
    logic [2:0]  gnt;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] gnt;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   m_hog;
  bit   m_rr;

  fb_arbiter_if bus ();

  fb_arbiter #(.HOG_LIMIT(HL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .gnt   (gnt),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration, written directly from the priority / anti-hog / round-robin rules.
  task automatic expect_grant(input logic [2:0] s);
    int   w;
    bit   waiting;
    exp_t e;
    waiting = s[1] | s[2];
    if (s[0] && (!waiting || m_hog < HL)) begin
      w = 0;
      if (waiting) m_hog = (m_hog < HL) ? m_hog + 1 : m_hog;
      else         m_hog = 0;
    end else begin
      m_hog = 0;
      if (s[1] && s[2]) w = m_rr ? 1 : 2;
      else              w = s[1] ? 1 : 2;
      m_rr = (w == 2);
    end
    e.gnt   = 3'(1 << w);
    e.we    = bus.rq_we[w];
    e.addr  = bus.rq_addr[20*w +: 20];
    e.wdata = bus.rq_wdata[16*w +: 16];
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.rq_stb  = 3'b000;
    bus.mem_ack = 1'b0;
    exp_q.delete();
    m_hog = 0;
    m_rr  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_stb(output bit ok);
    int n = 0;
    while (bus.mem_stb !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.mem_stb === 1'b1);
    if (!ok) check("mem_stb_timeout", 32'(bus.mem_stb), 32'd1);
  endtask

  // Act as the SRAM control FSM for one transaction: compare against the next
  // expected entry, hold mem_ack for ack_len cycles, clear rq_stb bits in 'drop'.
  task automatic serve(input int ack_len, input logic [15:0] rd, input logic [2:0] drop);
    exp_t e;
    bit   ok;
    wait_stb(ok);
    if (!ok) return;
    if (exp_q.size() == 0) begin
      check("unexpected_txn", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("gnt", 32'(gnt), 32'(e.gnt));
    check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
    check("mem_we", 32'(bus.mem_we), 32'(e.we));
    if (e.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
    check("busy", 32'(busy), 32'd1);
    check("rq_ack_pre", 32'(bus.rq_ack), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    for (int k = 0; k < ack_len; k++) begin
      #1;
      check("rq_ack", 32'(bus.rq_ack), 32'(e.gnt));
      check("rq_rdata", 32'(bus.rq_rdata), 32'(rd));
      check("mem_we_ack", 32'(bus.mem_we), 32'(e.we));
      if (k == 0) bus.rq_stb = bus.rq_stb & ~drop;
      @(negedge clk);
      check("mem_stb_release", 32'(bus.mem_stb), 32'd0);
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    #1;
    check("rq_ack_off", 32'(bus.rq_ack), 32'd0);
    @(negedge clk);
    check("gnt_idle", 32'(gnt), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("mem_addr_idle", 32'(bus.mem_addr), 32'd0);
  endtask

  initial begin
    bit ok;
    rst_n         = 1'b0;
    bus.rq_stb    = 3'b000;
    bus.rq_we     = 3'b000;
    bus.rq_addr   = '0;
    bus.rq_wdata  = '0;
    bus.mem_rdata = 16'h0000;
    bus.mem_ack   = 1'b0;
    m_hog = 0;
    m_rr  = 1'b1;

    // Reset state
    #3;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_mem_stb", 32'(bus.mem_stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rq_ack", 32'(bus.rq_ack), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Per-requester transaction data
    bus.rq_addr[19:0]    = 20'h12345;
    bus.rq_addr[39:20]   = 20'h00ABC;
    bus.rq_addr[59:40]   = 20'h54321;
    bus.rq_wdata[15:0]   = 16'hA5A5;
    bus.rq_wdata[31:16]  = 16'h739C;
    bus.rq_wdata[47:32]  = 16'hBEEF;
    bus.rq_we            = 3'b110;

    // Single write from requester 1, 2-cycle ack
    @(negedge clk);
    bus.rq_stb = 3'b010;
    expect_grant(3'b010);
    serve(2, 16'h0000, 3'b010);

    // Round-robin between requesters 1 and 2
    do_reset();
    bus.rq_stb = 3'b110;
    for (int i = 0; i < 4; i++) expect_grant(3'b110);
    for (int i = 0; i < 4; i++) serve(1, 16'h0000, (i == 3) ? 3'b111 : 3'b000);

    // Anti-hog with all three requesting continuously
    do_reset();
    bus.rq_stb = 3'b111;
    for (int i = 0; i < 8; i++) expect_grant(3'b111);
    for (int i = 0; i < 8; i++) serve(1, 16'h0000, (i == 7) ? 3'b111 : 3'b000);

    // Granted requester drops its strobe before the ack
    @(negedge clk);
    bus.rq_stb = 3'b100;
    expect_grant(3'b100);
    wait_stb(ok);
    bus.rq_stb = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("stb_drop_hold", 32'(bus.mem_stb), 32'd1);
    serve(1, 16'h0000, 3'b000);

    // Requester 0 read with read data during ack
    bus.rq_stb = 3'b001;
    expect_grant(3'b001);
    serve(2, 16'h1234, 3'b001);

    // Asynchronous reset in the middle of GRANT
    bus.rq_stb = 3'b010;
    wait_stb(ok);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_stb", 32'(bus.mem_stb), 32'd0);
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rq_ack", 32'(bus.rq_ack), 32'd0);
    bus.rq_stb = 3'b000;
    exp_q.delete();
    m_hog = 0;
    m_rr  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rq_stb = 3'b110;
    expect_grant(3'b110);
    serve(1, 16'h0000, 3'b111);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
